cpu_bus_sched: RTL and testbench

Shares the single Z80 memory bus between the CPU, a video fetch unit and a DMA engine, and throttles the CPU to a selected speed.
- The CPU runs only in cycles where hold=1.
- Speed comes from a fractional credit accumulator driven by the reference clock.
- Video has priority over DMA. DMA bursts are length-bounded, and a one-cycle gap after every burst guarantees the CPU a slot.
- Sits between the CPU core's hold input, the video controller and the DMA controller.

---
 rtl/cpu_bus_sched.sv | 156 +++++++++++++++
 tb/tb_cpu_bus_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_sched.sv
// cpu_bus_sched: shares the Z80 memory bus between the CPU, video fetch and DMA,
// and paces the CPU with a fractional credit accumulator on the reference clock.
// Optional build macro CPU_BUS_SCHED_CATCHUP_EN: ticks lost to video/DMA are
// remembered (up to 15) and handed back to the CPU in later free cycles.
//
// Handshake: vid_req/dma_req are level requests held by the requester; a grant
// (vid_gnt/dma_gnt) is registered and means the requester owns the bus in that
// very cycle. hold=1 means the CPU may execute this cycle. All outputs are
// registered and describe the state entered at the same clock edge.
module cpu_bus_sched #(
    parameter int FREF    = 250,
    parameter int F_SLOW  = 35,
    parameter int F_MID   = 70,
    parameter int F_FAST  = 140,
    parameter int VID_LEN = 4,
    parameter int DMA_MAX = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] speed_sel,
    input  logic       vid_req,
    output logic       vid_gnt,
    input  logic       dma_req,
    input  logic       dma_last,
    output logic       dma_gnt,
    output logic       hold,
    input  logic       stat_clr,
    output logic [7:0] ticks_lost,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] S_CPU = 2'd0;
    localparam logic [1:0] S_VID = 2'd1;
    localparam logic [1:0] S_DMA = 2'd2;
    localparam logic [1:0] S_GAP = 2'd3;

    logic [1:0] r_state;
    logic [8:0] r_acc;
    logic [7:0] r_cnt;
    logic       r_hold;
    logic       r_vid_gnt;
    logic       r_dma_gnt;
    logic [7:0] r_ticks_lost;

    logic [8:0] w_f;
    logic [8:0] w_sum;
    logic [8:0] w_acc_next;
    logic       w_tick;
    logic [1:0] w_state_next;
    logic [7:0] w_cnt_next;
    logic       w_bus_taken;
    logic       w_lost;
    logic       w_hold_next;

`ifdef CPU_BUS_SCHED_CATCHUP_EN
    logic [3:0] r_pend;
`endif

    // Select the credit added per reference cycle from the speed preset.
    always_comb begin
        w_f = 9'(FREF);
        case (speed_sel)
            2'b00:   w_f = 9'(F_SLOW);
            2'b01:   w_f = 9'(F_MID);
            2'b10:   w_f = 9'(F_FAST);
            default: w_f = 9'(FREF);
        endcase
    end

    // Fractional accumulator: a tick is one CPU cycle's worth of credit.
    always_comb begin
        w_sum      = r_acc + w_f;
        w_tick     = (w_sum >= 9'(FREF));
        w_acc_next = w_tick ? (w_sum - 9'(FREF)) : w_sum;
    end

    // Arbitration and burst length tracking; video beats DMA, every burst ends in a gap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_CPU: begin
                if (vid_req) begin
                    w_state_next = S_VID;
                    w_cnt_next   = 8'(VID_LEN - 1);
                end else if (dma_req) begin
                    w_state_next = S_DMA;
                    w_cnt_next   = 8'(DMA_MAX - 1);
                end
            end
            S_VID: begin
                if (r_cnt == 8'd0) w_state_next = S_GAP;
                else               w_cnt_next   = r_cnt - 8'd1;
            end
            S_DMA: begin
                if (dma_last || r_cnt == 8'd0) w_state_next = S_GAP;
                else                           w_cnt_next   = r_cnt - 8'd1;
            end
            default: w_state_next = S_CPU;
        endcase
    end

    // A tick falling in a cycle the bus goes to video/DMA is a tick the CPU lost.
    always_comb begin
        w_bus_taken = (w_state_next == S_VID) || (w_state_next == S_DMA);
        w_lost      = w_tick && w_bus_taken;
`ifdef CPU_BUS_SCHED_CATCHUP_EN
        w_hold_next = !w_bus_taken && (w_tick || (r_pend != 4'd0));
`else
        w_hold_next = !w_bus_taken && w_tick;
`endif
    end

    // State, accumulator, registered outputs and the lost-tick statistic.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_CPU;
            r_acc        <= 9'd0;
            r_cnt        <= 8'd0;
            r_hold       <= 1'b0;
            r_vid_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_ticks_lost <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_hold    <= w_hold_next;
            r_vid_gnt <= (w_state_next == S_VID);
            r_dma_gnt <= (w_state_next == S_DMA);
            if (stat_clr)
                r_ticks_lost <= 8'd0;
            else if (w_lost && r_ticks_lost != 8'hFF)
                r_ticks_lost <= r_ticks_lost + 8'd1;
        end
    end

`ifdef CPU_BUS_SCHED_CATCHUP_EN
    // Pending catch-up ticks: grow on each lost tick, drain on each extra hold.
    always_ff @(posedge clock) begin
        if (!reset_n || stat_clr)
            r_pend <= 4'd0;
        else if (w_lost && r_pend != 4'hF)
            r_pend <= r_pend + 4'd1;
        else if (w_hold_next && !w_tick)
            r_pend <= r_pend - 4'd1;
    end
`endif

    assign hold        = r_hold;
    assign vid_gnt     = r_vid_gnt;
    assign dma_gnt     = r_dma_gnt;
    assign ticks_lost  = r_ticks_lost;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_bus_sched.sv
// tb_cpu_bus_sched: bench for cpu_bus_sched with a bus-ownership model based on
// cumulative credit arithmetic, a per-cycle compare process, directed scenarios
// with hand-computed expectations and a randomized phase.
module tb_cpu_bus_sched;

  localparam int FREF    = 250;
  localparam int F_SLOW  = 35;
  localparam int F_MID   = 70;
  localparam int F_FAST  = 140;
  localparam int VID_LEN = 4;
  localparam int DMA_MAX = 16;

  localparam int OWN_CPU = 0;
  localparam int OWN_VID = 1;
  localparam int OWN_DMA = 2;
  localparam int OWN_GAP = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] speed_sel = 2'b00;
  logic       vid_req = 1'b0;
  logic       dma_req = 1'b0;
  logic       dma_last = 1'b0;
  logic       stat_clr = 1'b0;
  logic       vid_gnt;
  logic       dma_gnt;
  logic       hold;
  logic [7:0] ticks_lost;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  cpu_bus_sched #(
    .FREF(FREF), .F_SLOW(F_SLOW), .F_MID(F_MID), .F_FAST(F_FAST),
    .VID_LEN(VID_LEN), .DMA_MAX(DMA_MAX)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .speed_sel(speed_sel),
    .vid_req(vid_req),
    .vid_gnt(vid_gnt),
    .dma_req(dma_req),
    .dma_last(dma_last),
    .dma_gnt(dma_gnt),
    .hold(hold),
    .stat_clr(stat_clr),
    .ticks_lost(ticks_lost),
    .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ownership of the bus cycle by cycle; ticks come from total credit vs total ticks.
  int     m_own = OWN_CPU;
  int     m_left = 0;
  longint m_credit = 0;
  longint m_ticks = 0;
  int     m_lost_cnt = 0;
  int     m_pend = 0;
  bit     m_hold = 1'b0;
  bit     m_vid = 1'b0;
  bit     m_dma = 1'b0;

  function automatic int rate(input logic [1:0] s);
    case (s)
      2'd0:    return F_SLOW;
      2'd1:    return F_MID;
      2'd2:    return F_FAST;
      default: return FREF;
    endcase
  endfunction

  always @(posedge clock) begin : model
    bit tick;
    bit busy;
    if (!reset_n) begin
      m_own = OWN_CPU; m_left = 0; m_credit = 0; m_ticks = 0;
      m_lost_cnt = 0; m_pend = 0; m_hold = 0; m_vid = 0; m_dma = 0;
    end else begin
      m_credit += rate(speed_sel);
      tick = (m_credit >= (m_ticks + 1) * FREF);
      if (tick) m_ticks++;
      case (m_own)
        OWN_CPU: begin
          if (vid_req) begin m_own = OWN_VID; m_left = VID_LEN; end
          else if (dma_req) begin m_own = OWN_DMA; m_left = DMA_MAX; end
        end
        OWN_VID: begin
          m_left--;
          if (m_left == 0) m_own = OWN_GAP;
        end
        OWN_DMA: begin
          m_left--;
          if (dma_last || m_left == 0) m_own = OWN_GAP;
        end
        default: m_own = OWN_CPU;
      endcase
      busy  = (m_own == OWN_VID) || (m_own == OWN_DMA);
      m_vid = (m_own == OWN_VID);
      m_dma = (m_own == OWN_DMA);
`ifdef CPU_BUS_SCHED_CATCHUP_EN
      m_hold = !busy && (tick || m_pend > 0);
      if (stat_clr) m_pend = 0;
      else if (tick && busy) m_pend = (m_pend < 15) ? m_pend + 1 : 15;
      else if (m_hold && !tick) m_pend--;
`else
      m_hold = !busy && tick;
`endif
      if (stat_clr) m_lost_cnt = 0;
      else if (tick && busy) m_lost_cnt = (m_lost_cnt < 255) ? m_lost_cnt + 1 : 255;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("hold", {31'd0, hold}, {31'd0, m_hold});
      check("vid_gnt", {31'd0, vid_gnt}, {31'd0, m_vid});
      check("dma_gnt", {31'd0, dma_gnt}, {31'd0, m_dma});
      check("ticks_lost", {24'd0, ticks_lost}, m_lost_cnt);
      check("gnt_overlap", {31'd0, vid_gnt & dma_gnt}, 32'd0);
      check("gnt_with_hold", {31'd0, (vid_gnt | dma_gnt) & hold}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0; vid_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0; stat_clr = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
    check("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("rst_ticks_lost", {24'd0, ticks_lost}, 32'd0);
    check("rst_dbg_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int hold_cnt;
    int consec;
    bit prev;
    int vcount;
    int code;
    int exp_code;

    // Mid speed, idle bus: 70 evenly spaced holds in 250 cycles.
    speed_sel = 2'b01;
    apply_reset();
    hold_cnt = 0; consec = 0; prev = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (hold) hold_cnt++;
      if (hold && prev) consec++;
      prev = hold;
    end
    check("mid_hold_count", hold_cnt, 70);
    check("mid_consecutive", consec, 0);
    check("mid_ticks_lost", {24'd0, ticks_lost}, 0);

    // Full speed: hold every cycle from the first cycle after release.
    speed_sel = 2'b11;
    apply_reset();
    hold_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (hold) hold_cnt++;
    end
    check("full_hold_count", hold_cnt, 20);

    // Full speed video burst: 4 grant cycles, 4 lost ticks, then clear.
    apply_reset();
    @(negedge clock);
    vid_req = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (vid_gnt) begin vid_req = 1'b0; vcount++; end
    end
    check("vid_burst_len", vcount, 4);
    check("vid_ticks_lost", {24'd0, ticks_lost}, 4);
    stat_clr = 1'b1;
    @(negedge clock);
    check("stat_clr", {24'd0, ticks_lost}, 0);
    stat_clr = 1'b0;

    // Simultaneous requests: video 4, gap + CPU slot, DMA 16 (no last), then idle.
    apply_reset();
    @(negedge clock);
    vid_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      code = vid_gnt ? 1 : (dma_gnt ? 2 : 0);
      exp_code = (i < 4) ? 1 : (i < 6) ? 0 : (i < 22) ? 2 : 0;
      check($sformatf("arb_trace_%0d", i), code, exp_code);
      if (i == 4) check("gap_hold_full", {31'd0, hold}, 1);
      if (vid_gnt) vid_req = 1'b0;
      if (dma_gnt) dma_req = 1'b0;
    end
    check("arb_ticks_lost", {24'd0, ticks_lost}, 20);

    // Saturation: DMA hogging at full speed for long enough to lose >255 ticks.
    apply_reset();
    dma_req = 1'b1;
    repeat (400) @(negedge clock);
    check("ticks_lost_sat", {24'd0, ticks_lost}, 255);
    dma_req = 1'b0;

    // Mid speed with one video burst: lost ticks are dropped or recovered.
    speed_sel = 2'b01;
    apply_reset();
    hold_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (hold) hold_cnt++;
      if (vid_gnt) vid_req = 1'b0;
      if (i == 20) vid_req = 1'b1;
    end
    check("burst_lost_nonzero", {31'd0, ticks_lost != 8'd0}, 1);
`ifdef CPU_BUS_SCHED_CATCHUP_EN
    check("catchup_hold_count", hold_cnt, 70);
`else
    check("dropped_hold_count", hold_cnt + int'(ticks_lost), 70);
`endif

    // Reset in the middle of a DMA burst, then video arbitration from S_CPU.
    speed_sel = 2'b11;
    apply_reset();
    @(negedge clock);
    dma_req = 1'b1;
    repeat (5) @(negedge clock);
    check("pre_rst_dma_gnt", {31'd0, dma_gnt}, 1);
    reset_n = 1'b0;
    vid_req = 1'b1;
    @(negedge clock);
    check("midrst_dma_gnt", {31'd0, dma_gnt}, 0);
    check("midrst_hold", {31'd0, hold}, 0);
    check("midrst_ticks_lost", {24'd0, ticks_lost}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_vid_gnt", {31'd0, vid_gnt}, 1);
    check("post_rst_dma_gnt", {31'd0, dma_gnt}, 0);
    vid_req = 1'b0; dma_req = 1'b0;
    repeat (30) @(negedge clock);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 49) == 0) speed_sel = 2'($urandom_range(0, 3));
      if (vid_gnt) vid_req = 1'b0;
      else if (!vid_req && $urandom_range(0, 15) == 0) vid_req = 1'b1;
      if (dma_gnt) begin
        if ($urandom_range(0, 3) == 0) dma_req = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        dma_req = 1'b1;
      end
      dma_last = dma_gnt ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      stat_clr = ($urandom_range(0, 63) == 0);
    end
    @(negedge clock);
    reset_n = 1'b1; stat_clr = 1'b0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
